// File: rtl/iitb_pkg.sv
// iitb_pkg: shared sequencer state encoding, register-file constants and multi-transfer opcodes.
package iitb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam int NREGS = 8;
  localparam int REG_AW = $clog2(NREGS);
  localparam logic [3:0] LM = 4'b1100;
  localparam logic [3:0] SM = 4'b1101;
  localparam logic [3:0] LA = 4'b1110;
  localparam logic [3:0] SA = 4'b1111;
endpackage

// File: rtl/lsb_priority_enc.sv
// lsb_priority_enc: index of the lowest set bit of a mask, plus a flag that any bit is set.
module lsb_priority_enc #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  output logic [AW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = mask[i] ? AW'(i) : idx;
  end
  assign found = |mask;
endmodule

// File: rtl/multi_xfer_sequencer.sv
// multi_xfer_sequencer: expands LM/SM/LA/SA into one single-register memory micro-op per cycle,
// stalling fetch/decode until the final micro-op is accepted.
module multi_xfer_sequencer #(
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sig_multiple,
  input  logic              sig_all,
  input  logic              load,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_up,
  output logic              uop_valid,
  output logic [REG_AW-1:0] uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_load,
  output logic              uop_last,
  output logic              done
);
  import iitb_pkg::*;
  seq_state_t        state_q, state_d;
  logic [NREGS-1:0]  pend_q, pend_d, eff_mask;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ld_q, ld_d;
  logic [REG_AW-1:0] idx;
  logic              found, run, trigger, accept, one_left;
  lsb_priority_enc #(.N(NREGS), .AW(REG_AW)) u_enc (
    .mask  (pend_q),
    .idx   (idx),
    .found (found)
  );
  assign eff_mask = sig_all ? '1 : reg_mask;
  assign run      = state_q == RUN;
  assign trigger  = state_q == IDLE && start && (sig_multiple || sig_all) && !flush;
  assign accept   = run && !hold;
  // exactly one pending bit: clearing the lowest set bit leaves nothing
  assign one_left = found && (pend_q & (pend_q - NREGS'(1))) == '0;
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    ld_d    = ld_q;
    if (flush) begin
      state_d = IDLE;
      pend_d  = '0;
    end else if (trigger) begin
      state_d = |eff_mask ? RUN : DONE;
      pend_d  = eff_mask;
      addr_d  = base_addr;
      ld_d    = load;
    end else if (accept) begin
      state_d = one_left ? DONE : RUN;
      pend_d  = pend_q & (pend_q - NREGS'(1));
      addr_d  = addr_q + ADDR_W'(1);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      ld_q    <= ld_d;
    end
  end
  assign stall_up  = (trigger && |eff_mask) || (run && !(one_left && !hold));
  assign uop_valid = run;
  assign uop_reg   = run ? idx : '0;
  assign uop_addr  = run ? addr_q : '0;
  assign uop_load  = run && ld_q;
  assign uop_last  = run && one_left;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_multi_xfer_sequencer.sv
// tb_multi_xfer_sequencer: randomized and directed checks against a queue-based transfer model.
module tb_multi_xfer_sequencer;
  logic        clk = 0, reset = 1, start = 0, sig_multiple = 0, sig_all = 0, load = 0;
  logic [7:0]  reg_mask = 0;
  logic [15:0] base_addr = 0;
  logic        hold = 0, flush = 0;
  logic        stall_up, uop_valid, uop_load, uop_last, done;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic [23:0] obs, exp_v;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  multi_xfer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .sig_multiple(sig_multiple), .sig_all(sig_all),
    .load(load), .reg_mask(reg_mask), .base_addr(base_addr), .hold(hold), .flush(flush),
    .stall_up(stall_up), .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_addr(uop_addr),
    .uop_load(uop_load), .uop_last(uop_last), .done(done)
  );
  // {valid, reg, addr, load, last, stall_up, done}
  assign obs = {uop_valid, uop_reg, uop_addr, uop_load, uop_last, stall_up, done};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    start = 0; sig_multiple = 0; sig_all = 0; load = 0; reg_mask = 0; base_addr = 0; hold = 0; flush = 0;
  endtask
  task automatic run_seq(input string nm, input logic sm, input logic sa, input logic ld,
                         input logic [7:0] mask, input logic [15:0] base,
                         input logic [31:0] hpat, input logic noise);
    logic [2:0]  rq[$];
    logic [15:0] aq[$];
    logic [7:0]  eff;
    logic [15:0] a;
    logic        h;
    int          n, k, c;
    eff = sa ? 8'hFF : mask;
    a = base;
    for (int i = 0; i < 8; i++)
      if (eff[i]) begin rq.push_back(3'(i)); aq.push_back(a); a = a + 16'd1; end
    n = rq.size();
    idle_inputs();
    start = 1; sig_multiple = sm; sig_all = sa; load = ld; reg_mask = mask; base_addr = base;
    #1;
    exp_v = {1'b0, 3'd0, 16'd0, 1'b0, 1'b0, n != 0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL %s trigger: got %h expected %h", nm, obs, exp_v); end
    tick();
    start = 0;
    k = 0; c = 0;
    while (k < n && c < 64) begin
      hold = c < 32 ? hpat[c] : 1'b0;
      if (noise) begin
        start = 1'($urandom); sig_multiple = 1; reg_mask = 8'($urandom);
        base_addr = 16'($urandom); load = 1'($urandom);
      end
      #1;
      exp_v = {1'b1, rq[k], aq[k], ld, k == n - 1, !(k == n - 1 && !hold), 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL %s uop%0d cyc%0d: got %h expected %h", nm, k, c, obs, exp_v); end
      h = hold;
      tick();
      if (!h) k++;
      c++;
    end
    checks++;
    if (k != n) begin errors++; $display("FAIL %s budget: issued %0d expected %0d", nm, k, n); end
    hold = 0; start = noise;
    #1;
    exp_v = 24'h1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL %s done: got %h expected %h", nm, obs, exp_v); end
    tick();
    idle_inputs();
    #1;
    exp_v = 24'h0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL %s post-done: got %h expected %h", nm, obs, exp_v); end
  endtask
  task automatic test_reset;
    idle_inputs(); reset = 1;
    tick(); tick();
    exp_v = 24'h0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h expected %h", obs, exp_v); end
    reset = 0;
    tick();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset idle: got %h expected %h", obs, exp_v); end
  endtask
  task automatic test_directed;
    run_seq("lm_a5", 1, 0, 1, 8'b1010_0101, 16'h0040, 32'h0, 0);
    run_seq("sa_wrap", 1, 1, 0, 8'h00, 16'hFFFE, 32'h0, 0);
    run_seq("lm_zero", 1, 0, 1, 8'h00, 16'h1234, 32'h0, 0);
    run_seq("sm_hold", 1, 0, 0, 8'h06, 16'h0100, 32'h3, 0);
    run_seq("start_ignored", 1, 0, 1, 8'h0F, 16'h0010, 32'h0, 1);
  endtask
  task automatic test_flush;
    idle_inputs();
    start = 1; sig_all = 1; load = 1; base_addr = 16'h2000; flush = 1;
    #1;
    exp_v = 24'h0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL flush beats trigger: got %h expected %h", obs, exp_v); end
    tick();
    flush = 0;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      flush = i == 2;
      #1;
      exp_v = {1'b1, 3'(i), 16'h2000 + 16'(i), 1'b1, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL flush uop%0d: got %h expected %h", i, obs, exp_v); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = 24'h0;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL post-flush%0d: got %h expected %h", i, obs, exp_v); end
      tick();
    end
    run_seq("lm_after_flush", 1, 0, 1, 8'h81, 16'h0300, 32'h0, 0);
  endtask
  task automatic test_reset_mid;
    idle_inputs();
    start = 1; sig_multiple = 1; load = 0; reg_mask = 8'h3C; base_addr = 16'h0500;
    tick();
    start = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = 24'h0;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset mid%0d: got %h expected %h", i, obs, exp_v); end
      tick();
    end
  endtask
  task automatic test_random;
    logic sm, sa;
    for (int t = 0; t < 12; t++) begin
      sa = 1'($urandom);
      sm = sa ? 1'($urandom) : 1'b1;
      run_seq($sformatf("rand%0d", t), sm, sa, 1'($urandom), 8'($urandom), 16'($urandom),
              $urandom & $urandom, 1'($urandom));
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
